// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding 16-bit fetch with redirect draining and stall hold.
// Optional FETCH_STATS_EN macro enables the accepted-instruction counter on fetch_count.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus_2,
    output logic        valid,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] pend, pend_nxt;
    logic [15:0] instr_nxt, pp2_nxt;
    logic [15:0] redir_tgt;

    assign redir_tgt = {redirect_pc[15:1], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC_ALIGNED;
            pend        <= '0;
            instruction <= '0;
            pc_plus_2   <= '0;
        end else begin
            pc          <= pc_nxt;
            pend        <= pend_nxt;
            instruction <= instr_nxt;
            pc_plus_2   <= pp2_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        instr_nxt = instruction;
        pp2_nxt   = pc_plus_2;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ready && redirect) begin
                    pc_nxt = redir_tgt;
                end else if (imem_ready) begin
                    instr_nxt = imem_rdata;
                    pp2_nxt   = pc + 16'd2;
                    state_nxt = HOLD;
                end else if (redirect) begin
                    // Address must stay stable until the outstanding beat returns.
                    pend_nxt  = redir_tgt;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pend_nxt = redir_tgt;
                end
                if (imem_ready) begin
                    pc_nxt    = redirect ? redir_tgt : pend;
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redir_tgt;
                    state_nxt = REQ;
                end else if (!stall) begin
                    pc_nxt    = pc + 16'd2;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign valid     = (state == HOLD);
    assign imem_addr = pc;

`ifdef FETCH_STATS_EN
    logic        accept;
    logic [15:0] count_q;

    assign accept = (state == HOLD) && !redirect && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized self-checking bench for if_fetch_unit against a transaction-level reference model.
// Honours FETCH_STATS_EN the same way as the design.
module tb_if_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, imem_ready;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, valid;
    logic [15:0] imem_addr, instruction, pc_plus_2, fetch_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_plus_2(pc_plus_2), .valid(valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: fetch is "waiting" (boot), "busy" (request out), "flushing"
    // (request out, result to be thrown away) or "holding" (an instruction is held).
    int          m_phase;   // 0 boot, 1 busy, 2 flushing, 3 holding
    logic [15:0] m_addr, m_target, m_word, m_next, m_taken;

    function automatic logic [15:0] even(input logic [15:0] a);
        return a & 16'hFFFE;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_addr   = even(RST_PC);
        m_target = 16'h0000;
        m_word   = 16'h0000;
        m_next   = 16'h0000;
        m_taken  = 16'h0000;
    endtask

    task automatic model_edge();
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ready && !redirect) begin
                m_word  = imem_rdata;
                m_next  = m_addr + 16'd2;
                m_phase = 3;
            end else if (imem_ready) begin
                m_addr = even(redirect_pc);
            end else if (redirect) begin
                m_target = even(redirect_pc);
                m_phase  = 2;
            end
        end else if (m_phase == 2) begin
            if (redirect) m_target = even(redirect_pc);
            if (imem_ready) begin
                m_addr  = m_target;
                m_phase = 1;
            end
        end else begin
            if (redirect) begin
                m_addr  = even(redirect_pc);
                m_phase = 1;
            end else if (!stall) begin
`ifdef FETCH_STATS_EN
                m_taken = m_taken + 16'd1;
`endif
                m_addr  = m_addr + 16'd2;
                m_phase = 1;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("imem_req", {15'd0, imem_req}, {15'd0, (m_phase == 1 || m_phase == 2)});
        check_eq("valid", {15'd0, valid}, {15'd0, (m_phase == 3)});
        check_eq("imem_addr", imem_addr, m_addr);
        check_eq("instruction", instruction, m_word);
        check_eq("pc_plus_2", pc_plus_2, m_next);
        check_eq("fetch_count", fetch_count, m_taken);
    endtask

    task automatic step(input logic s, input logic rd, input logic [15:0] rpc,
                        input logic rdy, input logic [15:0] data);
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = data;
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Streaming with ready tied high: addresses 0,2,4..., valid every other cycle.
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'hA000);
        check_eq("first_req_addr", imem_addr, 16'h0000);
        for (int unsigned i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 16'hA001 + 16'(i));
        check_eq("stream_pc_plus_2", pc_plus_2, 16'h0006);

        // Hold 16'h1234 under stall for five cycles.
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
        for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b1, 16'hDEAD);
        check_eq("stall_hold_instr", instruction, 16'h1234);
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

        // Redirect to 0010, then drain with two redirects while memory is slow.
        step(1'b0, 1'b1, 16'h0010, 1'b1, 16'h0);
        check_eq("req_at_0010", imem_addr, 16'h0010);
        step(1'b0, 1'b1, 16'h0041, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0080, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("drain_addr_stable", imem_addr, 16'h0010);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'hBAD0);
        check_eq("drain_next_req", imem_addr, 16'h0080);

        // Redirect beats stall in HOLD.
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
        step(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0);
        check_eq("redirect_over_stall", {15'd0, valid}, 16'h0000);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0);
        check_eq("wrap_addr", imem_addr, 16'hFFFE);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h7777);
        check_eq("wrap_pc_plus_2", pc_plus_2, 16'h0000);
        step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0);
        check_eq("wrap_next_addr", imem_addr, 16'h0000);

        // Randomized traffic with occasional asynchronous resets.
        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                     16'($urandom), $urandom_range(0, 2) != 0, 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
